pc_next_unit: RTL and testbench

//  Program counter register and next-PC sequencer for the MIPS fetch stage. Sits directly

---
 rtl/pc_next_unit.sv | 118 +++++++++++
 tb/tb_pc_next_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_next_unit
//  Brief    : MIPS fetch PC register and next-PC sequencer. Handles sequential,
//             branch, jump and jump-register redirects, with an optional
//             branch-delay-slot FSM.
//  Revision : 1.0  initial release
// ============================================================================
module pc_next_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
    parameter bit          DELAY_SLOT   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] shifted_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        in_delay_slot,
    output logic        redirect_ign,
    output logic        misaligned
);

    typedef enum logic [0:0] {
        SEQ   = 1'b0,
        DELAY = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_target;
    logic [31:0] w_target_nxt;
    logic        r_fetch_valid;
    logic        r_redirect_ign;
    logic        w_redirect_ign_nxt;
    logic        r_misaligned;
    logic        w_misaligned_nxt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;
    logic [31:0] w_jr_tgt;
    logic [31:0] w_sel_tgt;
    logic        w_req;
    logic        w_accept;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_tgt   = w_pc_plus4 + shifted_offset;
    assign w_j_tgt    = {w_pc_plus4[31:28], jump_index, 2'b00};
    assign w_jr_tgt   = {jr_addr[31:2], 2'b00};

    // jr outranks jump, which outranks a taken branch
    assign w_sel_tgt  = jr ? w_jr_tgt : (jump ? w_j_tgt : w_br_tgt);
    assign w_req      = jr | jump | branch_taken;
    assign w_accept   = r_fetch_valid & ~stall;

    always_comb begin
        w_pc_nxt           = r_pc;
        w_state_nxt        = r_state;
        w_target_nxt       = r_target;
        w_redirect_ign_nxt = 1'b0;
        w_misaligned_nxt   = 1'b0;
        if (w_accept) begin
            if (DELAY_SLOT && (r_state == DELAY)) begin
                // Delay slot has executed: commit the stored target, drop new requests
                w_pc_nxt           = r_target;
                w_state_nxt        = SEQ;
                w_redirect_ign_nxt = w_req;
            end else begin
                w_pc_nxt = w_pc_plus4;
                if (w_req) begin
                    w_misaligned_nxt = jr & (jr_addr[1:0] != 2'b00);
                    if (DELAY_SLOT) begin
                        w_target_nxt = w_sel_tgt;
                        w_state_nxt  = DELAY;
                    end else begin
                        w_pc_nxt = w_sel_tgt;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc           <= RESET_VECTOR;
            r_state        <= SEQ;
            r_target       <= 32'd0;
            r_fetch_valid  <= 1'b0;
            r_redirect_ign <= 1'b0;
            r_misaligned   <= 1'b0;
        end else begin
            r_pc           <= w_pc_nxt;
            r_state        <= w_state_nxt;
            r_target       <= w_target_nxt;
            r_fetch_valid  <= 1'b1;
            r_redirect_ign <= w_redirect_ign_nxt;
            r_misaligned   <= w_misaligned_nxt;
        end
    end

    assign pc            = r_pc;
    assign pc_plus4      = w_pc_plus4;
    assign fetch_valid   = r_fetch_valid;
    assign in_delay_slot = (r_state == DELAY);
    assign redirect_ign  = r_redirect_ign;
    assign misaligned    = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_pc_next_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_next_unit
//  Brief    : Directed self-checking bench for pc_next_unit, covering both the
//             delay-slot build and the immediate-redirect build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_next_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] shifted_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_addr;

    logic [31:0] pc,  pc_plus4;
    logic        fetch_valid, in_delay_slot, redirect_ign, misaligned;
    logic [31:0] pc0, pc_plus4_0;
    logic        fetch_valid0, in_delay_slot0, redirect_ign0, misaligned0;

    int passed = 0;
    int total  = 0;

    pc_next_unit #(.RESET_VECTOR(32'h0040_0000), .DELAY_SLOT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .shifted_offset(shifted_offset), .jump(jump), .jump_index(jump_index),
        .jr(jr), .jr_addr(jr_addr), .pc(pc), .pc_plus4(pc_plus4),
        .fetch_valid(fetch_valid), .in_delay_slot(in_delay_slot),
        .redirect_ign(redirect_ign), .misaligned(misaligned)
    );

    pc_next_unit #(.RESET_VECTOR(32'h0040_0000), .DELAY_SLOT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .shifted_offset(shifted_offset), .jump(jump), .jump_index(jump_index),
        .jr(jr), .jr_addr(jr_addr), .pc(pc0), .pc_plus4(pc_plus4_0),
        .fetch_valid(fetch_valid0), .in_delay_slot(in_delay_slot0),
        .redirect_ign(redirect_ign0), .misaligned(misaligned0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
        shifted_offset = 32'd0; jump_index = 26'd0; jr_addr = 32'd0;
    endtask

    // Async reset pulse placed mid-cycle, released before the next rising edge
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #12;
        chk("rst_pc", pc, 32'h0040_0000);
        chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
        chk("rst_ds", {31'd0, in_delay_slot}, 32'd0);
        chk("rst_ign", {31'd0, redirect_ign}, 32'd0);
        chk("rst_mis", {31'd0, misaligned}, 32'd0);
        chk("rst_pc_ds0", pc0, 32'h0040_0000);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: first edge only raises fetch_valid, then sequential fetch
        step(); chk("t1_pc0", pc, 32'h0040_0000); chk("t1_fv", {31'd0, fetch_valid}, 32'd1);
        step(); chk("t1_pc1", pc, 32'h0040_0004);
        step(); chk("t1_pc2", pc, 32'h0040_0008);
        step(); chk("t1_pc3", pc, 32'h0040_000C);
        step(); chk("t1_pc4", pc, 32'h0040_0010);

        // 2: branch forward from 0x00400010
        branch_taken = 1'b1; shifted_offset = 32'h0000_0020;
        step(); chk("t2_slot", pc, 32'h0040_0014); chk("t2_ds", {31'd0, in_delay_slot}, 32'd1);
        idle_inputs();
        step(); chk("t2_tgt", pc, 32'h0040_0034); chk("t2_ds_clr", {31'd0, in_delay_slot}, 32'd0);

        // 2b: backward branch from 0x00400010 after a fresh reset
        do_reset();
        #1 chk("t2b_rst", pc, 32'h0040_0000);
        step(); step(); step(); step(); step();
        chk("t2b_at", pc, 32'h0040_0010);
        branch_taken = 1'b1; shifted_offset = 32'hFFFF_FFF0;
        step(); chk("t2b_slot", pc, 32'h0040_0014);
        idle_inputs();
        step(); chk("t2b_tgt", pc, 32'h0040_0004);

        // 3: jr to 0x10000004, then J from 0x10000008
        jr = 1'b1; jr_addr = 32'h1000_0004;
        step(); idle_inputs();
        step(); chk("t3_jr", pc, 32'h1000_0004);
        step(); chk("t3_at", pc, 32'h1000_0008);
        jump = 1'b1; jump_index = 26'h000_0100;
        step(); chk("t3_slot", pc, 32'h1000_000C);
        idle_inputs();
        step(); chk("t3_tgt", pc, 32'h1000_0400);

        // 4: simultaneous requests, jr wins, misaligned address
        jr = 1'b1; jump = 1'b1; branch_taken = 1'b1;
        jr_addr = 32'h0040_0102; jump_index = 26'h3FF_FFFF; shifted_offset = 32'h0000_0100;
        step(); chk("t4_slot", pc, 32'h1000_0404); chk("t4_mis", {31'd0, misaligned}, 32'd1);
        idle_inputs();
        step(); chk("t4_tgt", pc, 32'h0040_0100); chk("t4_mis_clr", {31'd0, misaligned}, 32'd0);

        // 5: stall in DELAY holds state; second branch in DELAY is ignored
        branch_taken = 1'b1; shifted_offset = 32'h0000_0040;
        step(); chk("t5_slot", pc, 32'h0040_0104);
        stall = 1'b1; shifted_offset = 32'h0000_0100;
        step(); step(); step();
        chk("t5_hold", pc, 32'h0040_0104);
        chk("t5_hold_ds", {31'd0, in_delay_slot}, 32'd1);
        chk("t5_hold_ign", {31'd0, redirect_ign}, 32'd0);
        stall = 1'b0;
        step(); chk("t5_tgt", pc, 32'h0040_0144); chk("t5_ign", {31'd0, redirect_ign}, 32'd1);
        idle_inputs();
        step(); chk("t5_seq", pc, 32'h0040_0148); chk("t5_ign_clr", {31'd0, redirect_ign}, 32'd0);

        // 6: async reset while in DELAY
        branch_taken = 1'b1; shifted_offset = 32'h0000_0010;
        step(); chk("t6_ds", {31'd0, in_delay_slot}, 32'd1);
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_pc", pc, 32'h0040_0000);
        chk("t6_rst_ds", {31'd0, in_delay_slot}, 32'd0);
        chk("t6_rst_fv", {31'd0, fetch_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(); chk("t6_fv_pc", pc, 32'h0040_0000);
        // 6b: immediate-redirect build takes the branch on the next edge
        branch_taken = 1'b1; shifted_offset = 32'h0000_0008;
        step();
        chk("t6b_pc_ds0", pc0, 32'h0040_000C);
        chk("t6b_nods", {31'd0, in_delay_slot0}, 32'd0);
        chk("t6b_pc_ds1", pc, 32'h0040_0004);
        idle_inputs();
        step();
        chk("t6b_seq_ds0", pc0, 32'h0040_0010);
        chk("t6b_tgt_ds1", pc, 32'h0040_000C);

        // Wrap-around: jr to 0xFFFFFFF8 then run sequentially past the top
        jr = 1'b1; jr_addr = 32'hFFFF_FFF8;
        step(); idle_inputs();
        step(); chk("wrap_a", pc, 32'hFFFF_FFF8);
        step(); chk("wrap_b", pc, 32'hFFFF_FFFC); chk("wrap_p4", pc_plus4, 32'h0000_0000);
        step(); chk("wrap_c", pc, 32'h0000_0000);
        chk("wrap_ds0_p4", pc_plus4_0, pc0 + 32'd4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
